// File: rtl/memory_responder_if.sv
// Request/response bundle between the control sequencer and the memory responder.
interface memory_responder_if;
  logic        read;
  logic        write;
  logic [8:0]  address;
  logic [31:0] write_data;
  logic [31:0] MDataIN;
  logic        mem_ready;
  logic        busy;
  logic        req_error;

  modport slave (
    input  read, write, address, write_data,
    output MDataIN, mem_ready, busy, req_error
  );

  modport master (
    output read, write, address, write_data,
    input  MDataIN, mem_ready, busy, req_error
  );
endinterface

// File: rtl/memory_responder.sv
// Wait-stated single-port word memory answering level read/write requests.
// state  | meaning
// IDLE   | waiting for exactly one of read/write
// WAIT   | counting down WAIT_STATES cycles with request latched
// ACCESS | array write or MDataIN load; mem_ready pulses next cycle
// HOLD   | waiting for read and write both low before re-arming
module memory_responder #(
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                clear_n,
  memory_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  // No reset on the array: contents survive clear_n.
  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        op_wr_q, op_wr_d;
  logic [31:0] mdata_q, mdata_d;
  logic        mem_ready_q, mem_ready_d;
  logic        req_error_q, req_error_d;
  logic        mem_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_wr_d     = op_wr_q;
    mdata_d     = mdata_q;
    mem_ready_d = 1'b0;
    req_error_d = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.read && bus.write) begin
          req_error_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (bus.read || bus.write) begin
          addr_d  = bus.address;
          wdata_d = bus.write_data;
          op_wr_d = bus.write;
          if (WS == 4'd0) begin
            state_d = ST_ACCESS;
          end else begin
            cnt_d   = WS;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_ready_d = 1'b1;
        state_d     = ST_HOLD;
        if (op_wr_q) mem_we = 1'b1;
        else         mdata_d = mem[addr_q];
      end
      ST_HOLD: begin
        if (!bus.read && !bus.write) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 9'd0;
      wdata_q     <= 32'd0;
      op_wr_q     <= 1'b0;
      mdata_q     <= 32'd0;
      mem_ready_q <= 1'b0;
      req_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_wr_q     <= op_wr_d;
      mdata_q     <= mdata_d;
      mem_ready_q <= mem_ready_d;
      req_error_q <= req_error_d;
    end
  end

  // Reset in the ACCESS cycle wins over the array write.
  always_ff @(posedge clk) begin
    if (clear_n && mem_we) mem[addr_q] <= wdata_q;
  end

  assign bus.MDataIN   = mdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.req_error = req_error_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
